// File: rtl/flash_ctrl.sv
// flash_ctrl: read-only memory-mapped controller for the on-board SPI flash.
// It sends the release-from-deep-power-down command (0xAB) after reset, then
// serves bus reads with single-bit SPI READ (0x03) frames in mode 0. The four
// flash bytes of a word are returned little-endian, and ready_out pulses once
// per read.
module flash_ctrl #(
    parameter int CLK_DIV     = 1,
    parameter int WAKE_CYCLES = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    output logic        ready_out,
    output logic        flash_clk,
    output logic        flash_csn,
    output logic        flash_io0_out,
    output logic        flash_io0_en,
    input  logic        flash_io1_in
);

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam int                WAKE_W    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [31:0]       WAKE_WORD = 32'hAB00_0000;

    state_t              state;
    logic [31:0]         shift_out;   // outgoing bits, MSB is the next bit on io0
    logic [31:0]         rx;          // incoming data bits, first flash byte ends up in [31:24]
    logic [31:0]         data;        // last completed word, already byte-swapped
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          bit_cnt;
    logic [WAKE_W-1:0]   wake_cnt;

    logic [31:0]         cmd_word;
    logic                shifting;
    logic                phase_end;
    logic                last_bit;
    logic                unused_addr;

    assign cmd_word  = {8'h03, address_in[23:2], 2'b00};
    // Upper address bits alias (decode is external) and the byte offset is implied.
    assign unused_addr = ^{address_in[31:24], address_in[1:0]};

    // The bit engine runs in SHIFT and in WAKE_CMD once csn has been pulled low.
    assign shifting  = (state == SHIFT) || ((state == WAKE_CMD) && !flash_csn);
    assign phase_end = (div_cnt == DIV_LAST);
    assign last_bit  = (state == SHIFT) ? (bit_cnt == 6'd63) : (bit_cnt == 6'd7);

    // Bus read data is gated by the select so it can be ORed onto the shared bus.
    assign read_value_out = sel_in ? data : 32'h0;

    // Controller FSM with registered SPI pins and ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= WAKE_CMD;
            flash_csn     <= 1'b1;
            flash_clk     <= 1'b0;
            flash_io0_out <= 1'b0;
            flash_io0_en  <= 1'b0;
            ready_out     <= 1'b0;
            data          <= 32'h0;
            shift_out     <= WAKE_WORD;
            rx            <= 32'h0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            wake_cnt      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values; later assignments below win.
            ready_out <= 1'b0;
            if (shifting) begin
                if (!phase_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (!flash_clk) begin
                        // Rising edge: the flash holds io1 stable here.
                        flash_clk <= 1'b1;
                        if ((state == SHIFT) && bit_cnt[5]) begin
                            rx <= {rx[30:0], flash_io1_in};
                        end
                    end else begin
                        // Falling edge: present the next outgoing bit (zeros after cmd+addr).
                        flash_clk     <= 1'b0;
                        shift_out     <= {shift_out[30:0], 1'b0};
                        flash_io0_out <= shift_out[30];
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (state == SHIFT) begin
                                state         <= DONE;
                                flash_csn     <= 1'b1;
                                flash_io0_en  <= 1'b0;
                                flash_io0_out <= 1'b0;
                                ready_out     <= 1'b1;
                                data          <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                            end else begin
                                // csn rises one cycle later, in WAKE_WAIT.
                                state <= WAKE_WAIT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
            end else begin
                case (state)
                    WAKE_CMD: begin
                        // First cycle after reset: open the wake frame.
                        flash_csn     <= 1'b0;
                        flash_io0_en  <= 1'b1;
                        flash_io0_out <= shift_out[31];
                    end
                    WAKE_WAIT: begin
                        if (!flash_csn) begin
                            flash_csn     <= 1'b1;
                            flash_io0_en  <= 1'b0;
                            flash_io0_out <= 1'b0;
                            wake_cnt      <= '0;
                        end else if (wake_cnt == WAKE_LAST) begin
                            wake_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            wake_cnt <= wake_cnt + 1'b1;
                        end
                    end
                    IDLE: begin
                        if (sel_in && read_in) begin
                            shift_out     <= cmd_word;
                            flash_csn     <= 1'b0;
                            flash_io0_en  <= 1'b1;
                            flash_io0_out <= cmd_word[31];
                            div_cnt       <= '0;
                            bit_cnt       <= '0;
                            state         <= SETUP;
                        end
                    end
                    SETUP:   state <= SHIFT;
                    DONE:    state <= IDLE;
                    default: state <= WAKE_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed bench for flash_ctrl with behavioural SPI flash models.
// Two instances: CLK_DIV=1 for most vectors, CLK_DIV=3 for the divider vector.
// Flash content: byte at address a = ((a[1:0]+1)*0x11) ^ (a[9:2]-1), so
//   word 0x000000 -> 0xBBCCDDEE, 0x100004 -> 0x44332211, 0x000008 -> 0x45322310.
module tb_flash_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] addr1 = 32'h0, rv1;
    logic        sel1 = 1'b0, rd1 = 1'b0, rdy1, fclk1, csn1, io0_1, en1;
    logic        io1_1 = 1'b0;
    logic [31:0] addr3 = 32'h0, rv3;
    logic        sel3 = 1'b0, rd3 = 1'b0, rdy3, fclk3, csn3, io0_3, en3;
    logic        io1_3 = 1'b0;

    flash_ctrl #(.CLK_DIV(1), .WAKE_CYCLES(48)) dut1 (
        .clk(clk), .reset(reset), .address_in(addr1), .sel_in(sel1), .read_in(rd1),
        .read_value_out(rv1), .ready_out(rdy1), .flash_clk(fclk1), .flash_csn(csn1),
        .flash_io0_out(io0_1), .flash_io0_en(en1), .flash_io1_in(io1_1)
    );

    flash_ctrl #(.CLK_DIV(3), .WAKE_CYCLES(48)) dut3 (
        .clk(clk), .reset(reset), .address_in(addr3), .sel_in(sel3), .read_in(rd3),
        .read_value_out(rv3), .ready_out(rdy3), .flash_clk(fclk3), .flash_csn(csn3),
        .flash_io0_out(io0_3), .flash_io0_en(en3), .flash_io1_in(io1_3)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Data bit the flash drives after rising edge n of a frame whose first 32 bits were cap.
    function automatic logic model_bit(input logic [31:0] cap, input int n);
        logic [23:0] a;
        logic [7:0]  b;
        int          k;
        if (n < 32 || n > 63) return 1'b0;
        k = n - 32;
        a = cap[23:0] + 24'(k / 8);
        b = 8'((int'(a[1:0]) + 1) * 17) ^ (a[9:2] - 8'd1);
        return b[7 - (k % 8)];
    endfunction

    // Flash model for dut1: capture io0 on rising edges, drive io1 on falling edges.
    int          fc1 = 0, last_cnt1 = 0;
    logic [31:0] cap1 = 32'h0, last_cap1 = 32'h0;
    always @(posedge fclk1) if (!csn1) begin
        if (fc1 < 32) cap1 = {cap1[30:0], io0_1};
        fc1++;
    end
    always @(negedge fclk1) if (!csn1) io1_1 = model_bit(cap1, fc1);
    always @(posedge csn1) begin
        last_cap1 = cap1; last_cnt1 = fc1; fc1 = 0; cap1 = 32'h0;
    end

    // Flash model for dut3.
    int          fc3 = 0;
    logic [31:0] cap3 = 32'h0, last_cap3 = 32'h0;
    always @(posedge fclk3) if (!csn3) begin
        if (fc3 < 32) cap3 = {cap3[30:0], io0_3};
        fc3++;
    end
    always @(negedge fclk3) if (!csn3) io1_3 = model_bit(cap3, fc3);
    always @(posedge csn3) begin
        last_cap3 = cap3; fc3 = 0; cap3 = 32'h0;
    end

    // Issue a read at the current negedge and wait (bounded) for ready_out.
    // lat counts negedges from the request to the ready cycle; hi/lo are the
    // lengths of the last complete flash_clk high and low phases.
    task automatic do_read(input bit d3, input logic [31:0] a, input bit hold,
                           output int lat, output logic [31:0] val,
                           output int hi_run, output int lo_run);
        logic c, prev;
        int   run;
        if (d3) begin addr3 = a; sel3 = 1'b1; rd3 = 1'b1; end
        else    begin addr1 = a; sel1 = 1'b1; rd1 = 1'b1; end
        lat = 0; run = 0; hi_run = 0; lo_run = 0; val = 32'h0;
        prev = d3 ? fclk3 : fclk1;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            c = d3 ? fclk3 : fclk1;
            if (c != prev) begin
                if (prev) hi_run = run; else lo_run = run;
                run = 1;
            end else begin
                run++;
            end
            prev = c;
            if (d3 ? rdy3 : rdy1) begin
                val = d3 ? rv3 : rv1;
                break;
            end
        end
        if (!hold) begin
            if (d3) begin sel3 = 1'b0; rd3 = 1'b0; end
            else    begin sel1 = 1'b0; rd1 = 1'b0; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, hr, lr, n, st, high, early, busy;
        logic [31:0] v;

        // Reset state, with a read request already held for the wake test.
        addr1 = 32'h0; sel1 = 1'b1; rd1 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csn", csn1, 1);
        check("rst_clk", fclk1, 0);
        check("rst_io0_en", en1, 0);
        check("rst_io0", io0_1, 0);
        check("rst_ready", rdy1, 0);
        check("rst_rdata", rv1, 32'h0);
        reset = 1'b0;

        // Wake: 0xAB frame, csn high gap, no ready before IDLE.
        st = 0; high = 0; early = 0;
        for (int i = 0; i < 400 && st < 3; i++) begin
            @(negedge clk);
            if (rdy1) early = 1;
            case (st)
                0: if (!csn1) st = 1;
                1: if (csn1) begin
                       st = 2; high = 1;
                       check("wake_bits", last_cap1[7:0], 8'hAB);
                       check("wake_len", last_cnt1, 8);
                   end
                default: if (csn1) high++; else st = 3;
            endcase
        end
        check("wake_done", st, 3);
        check("wake_no_ready", early, 0);
        check("wake_gap_ge48", (high >= 48), 1);
        do_read(1'b0, 32'h0, 1'b0, lat, v, hr, lr);
        check("wake_read_data", v, 32'hBBCCDDEE);
        check("wake_read_cmd", last_cap1, 32'h0300_0000);
        @(negedge clk);

        // Basic read with exact latency and one-cycle ready.
        do_read(1'b0, 32'h0010_0004, 1'b0, lat, v, hr, lr);
        check("basic_latency", lat, 130);
        check("basic_data", v, 32'h44332211);
        check("basic_cmd", last_cap1, 32'h0310_0004);
        check("basic_clk_hi", hr, 1);
        check("basic_clk_lo", lr, 1);
        @(negedge clk);
        check("basic_ready_width", rdy1, 0);

        // Bus hygiene: deselected read data is zero; writes do nothing.
        sel1 = 1'b0;
        #1 check("desel_rdata", rv1, 32'h0);
        @(negedge clk);
        sel1 = 1'b1; rd1 = 1'b0; addr1 = 32'h0010_0004;
        #1 check("idle_hold_rdata", rv1, 32'h44332211);
        busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (!csn1 || rdy1) busy++;
        end
        check("write_ignored", busy, 0);
        sel1 = 1'b0;
        @(negedge clk);

        // Address bits [31:24] alias.
        do_read(1'b0, 32'hFF10_0004, 1'b0, lat, v, hr, lr);
        check("alias_data", v, 32'h44332211);
        check("alias_cmd", last_cap1, 32'h0310_0004);
        @(negedge clk);

        // Back-to-back: 0x0 then 0x8 with the request held through DONE.
        do_read(1'b0, 32'h0, 1'b1, lat, v, hr, lr);
        check("b2b_first_data", v, 32'hBBCCDDEE);
        addr1 = 32'h8;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (csn1) n++; else break;
        end
        check("b2b_csn_gap", n, 2);
        do_read(1'b0, 32'h8, 1'b0, lat, v, hr, lr);
        check("b2b_second_latency", lat, 129);
        check("b2b_second_data", v, 32'h45322310);
        @(negedge clk);

        // Reset in the middle of SHIFT (bit 40).
        addr1 = 32'h0010_0004; sel1 = 1'b1; rd1 = 1'b1;
        n = 0;
        while (fc1 < 40 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_bit40", (fc1 >= 40), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_csn", csn1, 1);
        check("midrst_clk", fclk1, 0);
        check("midrst_ready", rdy1, 0);
        check("midrst_io0_en", en1, 0);
        @(negedge clk);
        check("midrst_rdata", rv1, 32'h0);
        sel1 = 1'b0; rd1 = 1'b0;
        reset = 1'b0;
        repeat (120) @(negedge clk);
        do_read(1'b0, 32'h8, 1'b0, lat, v, hr, lr);
        check("postrst_latency", lat, 130);
        check("postrst_data", v, 32'h45322310);
        @(negedge clk);

        // Divider: CLK_DIV=3 instance.
        do_read(1'b1, 32'h0010_0004, 1'b0, lat, v, hr, lr);
        check("div3_latency", lat, 386);
        check("div3_data", v, 32'h44332211);
        check("div3_cmd", last_cap3, 32'h0310_0004);
        check("div3_clk_hi", hr, 3);
        check("div3_clk_lo", lr, 3);
        @(negedge clk);
        check("div3_ready_width", rdy3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
